spu_wb_queue: RTL and testbench

Write-back queue for the Cell SPU. It sits between the even and odd execution pipes and the single write port of the 128×128-bit SPU register file. Each pipe can deliver at most one result per cycle. The queue buffers those results in a small in-order FIFO and drains at most one per cycle into the register file's write port. It also reports pending-write hazards so the issue stage can stall reads of registers that are still queued.

---
 rtl/spu_wb_queue.sv | 110 +++++++++++
 tb/tb_spu_wb_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spu_wb_queue.sv
// Write-back queue that merges even/odd pipe results into the single register-file write port.
// Holds results in an in-order circular FIFO and flags reads of registers that are still queued.
module spu_wb_queue #(
   parameter int unsigned WIDTH   = 128,
   parameter int unsigned REGBITS = 7,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ev_valid,
   input  logic [REGBITS-1:0]       ev_wa,
   input  logic [WIDTH-1:0]         ev_wd,
   output logic                     ev_ready,
   input  logic                     od_valid,
   input  logic [REGBITS-1:0]       od_wa,
   input  logic [WIDTH-1:0]         od_wd,
   output logic                     od_ready,
   output logic                     regwrite,
   output logic [REGBITS-1:0]       wa,
   output logic [WIDTH-1:0]         wd,
   input  logic [REGBITS-1:0]       qa1,
   input  logic [REGBITS-1:0]       qa2,
   output logic                     busy1,
   output logic                     busy2,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0]      head_q, head_d;
   logic [PW-1:0]      tail_q, tail_d;
   logic [CW-1:0]      count_q, count_d;
   logic [REGBITS-1:0] addr_q [DEPTH];
   logic [REGBITS-1:0] addr_d [DEPTH];
   logic [WIDTH-1:0]   data_q [DEPTH];
   logic [WIDTH-1:0]   data_d [DEPTH];

   logic [CW-1:0]      free;
   logic               ev_push, od_push, pop;
   logic [PW-1:0]      od_slot;
   logic [PW-1:0]      off;

   // Readiness looks only at registered occupancy, never at this cycle's drain.
   always_comb begin
      free     = CW'(DEPTH) - count_q;
      ev_ready = (free >= CW'(1));
      od_ready = ev_valid ? (free >= CW'(2)) : (free >= CW'(1));
   end

   // r0 writes handshake but are never stored.
   assign ev_push = ev_valid && ev_ready && (ev_wa != '0);
   assign od_push = od_valid && od_ready && (od_wa != '0);
   assign pop     = (count_q != '0);
   assign od_slot = tail_q + PW'(ev_push);

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      if (ev_push) begin
         addr_d[tail_q] = ev_wa;
         data_d[tail_q] = ev_wd;
      end
      if (od_push) begin
         addr_d[od_slot] = od_wa;
         data_d[od_slot] = od_wd;
      end
      tail_d  = tail_q + PW'(ev_push) + PW'(od_push);
      head_d  = head_q + PW'(pop);
      count_d = count_q + CW'(ev_push) + CW'(od_push) - CW'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      data_q <= data_d;
   end

   assign regwrite = (count_q != '0);
   assign wa       = addr_q[head_q];
   assign wd       = data_q[head_q];
   assign count    = count_q;

   // A slot is live when its distance from head is below the occupancy.
   always_comb begin
      busy1 = 1'b0;
      busy2 = 1'b0;
      off   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         off = PW'(i) - head_q;
         if ({1'b0, off} < count_q) begin
            if (addr_q[i] == qa1) busy1 = 1'b1;
            if (addr_q[i] == qa2) busy2 = 1'b1;
         end
      end
      busy1 = busy1 && (qa1 != '0);
      busy2 = busy2 && (qa2 != '0);
   end

endmodule

// File: tb/tb_spu_wb_queue.sv
// Directed bench for spu_wb_queue: a per-cycle vector table on a DEPTH=4 queue plus a
// hand-written full-queue sequence on a DEPTH=2 instance.
module tb_spu_wb_queue;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // DEPTH=4 instance
   logic         reset, ev_valid, od_valid, ev_ready, od_ready, regwrite, busy1, busy2;
   logic [6:0]   ev_wa, od_wa, wa, qa1, qa2;
   logic [127:0] ev_wd, od_wd, wd;
   logic [2:0]   count;

   spu_wb_queue #(.WIDTH(128), .REGBITS(7), .DEPTH(4)) u_dut (
      .clk(clk), .reset(reset),
      .ev_valid(ev_valid), .ev_wa(ev_wa), .ev_wd(ev_wd), .ev_ready(ev_ready),
      .od_valid(od_valid), .od_wa(od_wa), .od_wd(od_wd), .od_ready(od_ready),
      .regwrite(regwrite), .wa(wa), .wd(wd),
      .qa1(qa1), .qa2(qa2), .busy1(busy1), .busy2(busy2), .count(count)
   );

   // DEPTH=2 instance, the only size where dual issue can reach full
   logic         reset2, ev_valid2, od_valid2, ev_ready2, od_ready2, regwrite2, busy1_2, busy2_2;
   logic [6:0]   ev_wa2, od_wa2, wa2, qa1_2, qa2_2;
   logic [127:0] ev_wd2, od_wd2, wd2;
   logic [1:0]   count2;

   spu_wb_queue #(.WIDTH(128), .REGBITS(7), .DEPTH(2)) u_dut2 (
      .clk(clk), .reset(reset2),
      .ev_valid(ev_valid2), .ev_wa(ev_wa2), .ev_wd(ev_wd2), .ev_ready(ev_ready2),
      .od_valid(od_valid2), .od_wa(od_wa2), .od_wd(od_wd2), .od_ready(od_ready2),
      .regwrite(regwrite2), .wa(wa2), .wd(wd2),
      .qa1(qa1_2), .qa2(qa2_2), .busy1(busy1_2), .busy2(busy2_2), .count(count2)
   );

   typedef struct {
      logic         rst;
      logic         ev_v;
      logic [6:0]   ev_a;
      logic [127:0] ev_d;
      logic         od_v;
      logic [6:0]   od_a;
      logic [127:0] od_d;
      logic [6:0]   q1, q2;
      logic         chk;
      logic         e_evr, e_odr, e_rw;
      logic [6:0]   e_wa;
      logic [127:0] e_wd;
      logic         e_b1, e_b2;
      logic [2:0]   e_cnt;
   } vec_t;

   localparam int NV = 26;
   vec_t vecs [NV];
   logic [127:0] a5;

   function automatic vec_t mk(int rst, int evv, int eva, logic [127:0] evd,
                               int odv, int oda, logic [127:0] odd, int q1, int q2, int chk,
                               int evr, int odr, int rw, int ewa, logic [127:0] ewd,
                               int b1, int b2, int cnt);
      vec_t v;
      v.rst = 1'(rst);  v.ev_v = 1'(evv);  v.ev_a = 7'(eva);  v.ev_d = evd;
      v.od_v = 1'(odv); v.od_a = 7'(oda);  v.od_d = odd;
      v.q1 = 7'(q1);    v.q2 = 7'(q2);     v.chk = 1'(chk);
      v.e_evr = 1'(evr); v.e_odr = 1'(odr); v.e_rw = 1'(rw);
      v.e_wa = 7'(ewa); v.e_wd = ewd;
      v.e_b1 = 1'(b1);  v.e_b2 = 1'(b2);   v.e_cnt = 3'(cnt);
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      a5 = {16{8'hA5}};
      //              rst ev ea  ed       od oa  odat     q1  q2 chk evr odr rw wa  wd       b1 b2 cnt
      vecs[0]  = mk(1, 0, 0,  0,       0, 0,  0,       0,  0, 0,  0, 0, 0, 0,  0,       0, 0, 0);
      vecs[1]  = mk(1, 0, 0,  0,       0, 0,  0,       0,  0, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[2]  = mk(0, 1, 5,  a5,      0, 0,  0,       5,  0, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[3]  = mk(0, 0, 0,  0,       0, 0,  0,       5,  0, 1,  1, 1, 1, 5,  a5,      1, 0, 1);
      vecs[4]  = mk(0, 0, 0,  0,       0, 0,  0,       5,  0, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[5]  = mk(0, 1, 9,  'h1,     1, 9,  'h2,     9,  5, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[6]  = mk(0, 0, 0,  0,       0, 0,  0,       9,  5, 1,  1, 1, 1, 9,  'h1,     1, 0, 2);
      vecs[7]  = mk(0, 0, 0,  0,       0, 0,  0,       9,  5, 1,  1, 1, 1, 9,  'h2,     1, 0, 1);
      vecs[8]  = mk(0, 0, 0,  0,       0, 0,  0,       9,  5, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[9]  = mk(0, 1, 0,  'hDEAD,  1, 7,  'h77,    0,  7, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[10] = mk(0, 0, 0,  0,       0, 0,  0,       0,  7, 1,  1, 1, 1, 7,  'h77,    0, 1, 1);
      vecs[11] = mk(0, 0, 0,  0,       0, 0,  0,       0,  7, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[12] = mk(0, 1, 1,  'h11,    1, 2,  'h12,    1,  2, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[13] = mk(0, 1, 3,  'h13,    1, 4,  'h14,    0,  0, 1,  1, 1, 1, 1,  'h11,    0, 0, 2);
      vecs[14] = mk(0, 1, 5,  'h15,    1, 6,  'h16,    0,  0, 1,  1, 0, 1, 2,  'h12,    0, 0, 3);
      vecs[15] = mk(0, 1, 7,  'h17,    1, 8,  'h18,    0,  0, 1,  1, 0, 1, 3,  'h13,    0, 0, 3);
      vecs[16] = mk(0, 0, 0,  0,       0, 0,  0,       5,  6, 1,  1, 1, 1, 4,  'h14,    1, 0, 3);
      vecs[17] = mk(0, 0, 0,  0,       0, 0,  0,       7,  4, 1,  1, 1, 1, 5,  'h15,    1, 0, 2);
      vecs[18] = mk(0, 0, 0,  0,       0, 0,  0,       8,  0, 1,  1, 1, 1, 7,  'h17,    0, 0, 1);
      vecs[19] = mk(0, 0, 0,  0,       0, 0,  0,       0,  0, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[20] = mk(0, 1, 10, 'hA0,    1, 11, 'hA1,    0,  0, 1,  1, 1, 0, 0,  0,       0, 0, 0);
      vecs[21] = mk(0, 1, 12, 'hA2,    1, 13, 'hA3,    12, 13, 1, 1, 1, 1, 10, 'hA0,    0, 0, 2);
      vecs[22] = mk(1, 1, 14, 'hA4,    0, 0,  0,       12, 13, 1, 1, 0, 1, 11, 'hA1,    1, 1, 3);
      vecs[23] = mk(0, 0, 0,  0,       0, 0,  0,       12, 13, 1, 1, 1, 0, 0,  0,       0, 0, 0);
      vecs[24] = mk(0, 0, 0,  0,       0, 0,  0,       11, 0,  1, 1, 1, 0, 0,  0,       0, 0, 0);
      vecs[25] = mk(0, 0, 0,  0,       0, 0,  0,       0,  0,  1, 1, 1, 0, 0,  0,       0, 0, 0);

      reset = 1'b1; ev_valid = 1'b0; od_valid = 1'b0; ev_wa = '0; od_wa = '0;
      ev_wd = '0; od_wd = '0; qa1 = '0; qa2 = '0;
      reset2 = 1'b1; ev_valid2 = 1'b0; od_valid2 = 1'b0; ev_wa2 = '0; od_wa2 = '0;
      ev_wd2 = '0; od_wd2 = '0; qa1_2 = '0; qa2_2 = '0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         reset = vecs[i].rst;
         ev_valid = vecs[i].ev_v; ev_wa = vecs[i].ev_a; ev_wd = vecs[i].ev_d;
         od_valid = vecs[i].od_v; od_wa = vecs[i].od_a; od_wd = vecs[i].od_d;
         qa1 = vecs[i].q1; qa2 = vecs[i].q2;
         #1;
         if (vecs[i].chk) begin
            check($sformatf("v%0d ev_ready", i), 128'(ev_ready), 128'(vecs[i].e_evr));
            check($sformatf("v%0d od_ready", i), 128'(od_ready), 128'(vecs[i].e_odr));
            check($sformatf("v%0d regwrite", i), 128'(regwrite), 128'(vecs[i].e_rw));
            check($sformatf("v%0d busy1", i), 128'(busy1), 128'(vecs[i].e_b1));
            check($sformatf("v%0d busy2", i), 128'(busy2), 128'(vecs[i].e_b2));
            check($sformatf("v%0d count", i), 128'(count), 128'(vecs[i].e_cnt));
            if (vecs[i].e_rw) begin
               check($sformatf("v%0d wa", i), 128'(wa), 128'(vecs[i].e_wa));
               check($sformatf("v%0d wd", i), wd, vecs[i].e_wd);
            end
         end
      end
      @(negedge clk);
      reset = 1'b0; ev_valid = 1'b0; od_valid = 1'b0;

      // Full-queue corner on DEPTH=2: dual push from empty reaches full.
      reset2 = 1'b1;
      @(negedge clk);
      #1;
      check("d2 reset count", 128'(count2), 128'(0));
      check("d2 reset ev_ready", 128'(ev_ready2), 128'(1));
      check("d2 reset od_ready", 128'(od_ready2), 128'(1));
      check("d2 reset regwrite", 128'(regwrite2), 128'(0));
      @(negedge clk);
      reset2 = 1'b0;
      ev_valid2 = 1'b1; ev_wa2 = 7'd1; ev_wd2 = 128'h21;
      od_valid2 = 1'b1; od_wa2 = 7'd2; od_wd2 = 128'h22;
      #1;
      check("d2 empty od_ready", 128'(od_ready2), 128'(1));
      @(negedge clk);
      ev_wa2 = 7'd3; ev_wd2 = 128'h23;
      od_wa2 = 7'd4; od_wd2 = 128'h24;
      qa1_2 = 7'd2; qa2_2 = 7'd3;
      #1;
      check("d2 full count", 128'(count2), 128'(2));
      check("d2 full ev_ready", 128'(ev_ready2), 128'(0));
      check("d2 full od_ready", 128'(od_ready2), 128'(0));
      check("d2 full wa", 128'(wa2), 128'(1));
      check("d2 full wd", wd2, 128'h21);
      check("d2 full busy1", 128'(busy1_2), 128'(1));
      check("d2 full busy2", 128'(busy2_2), 128'(0));
      @(negedge clk);
      #1;
      check("d2 after pop count", 128'(count2), 128'(1));
      check("d2 after pop ev_ready", 128'(ev_ready2), 128'(1));
      check("d2 after pop od_ready", 128'(od_ready2), 128'(0));
      check("d2 after pop wa", 128'(wa2), 128'(2));
      check("d2 after pop wd", wd2, 128'h22);
      @(negedge clk);
      ev_valid2 = 1'b0; od_valid2 = 1'b0;
      #1;
      check("d2 refill count", 128'(count2), 128'(1));
      check("d2 refill wa", 128'(wa2), 128'(3));
      check("d2 refill wd", wd2, 128'h23);
      check("d2 refill busy2", 128'(busy2_2), 128'(1));
      check("d2 refill busy1", 128'(busy1_2), 128'(0));
      @(negedge clk);
      #1;
      check("d2 drained count", 128'(count2), 128'(0));
      check("d2 drained regwrite", 128'(regwrite2), 128'(0));
      check("d2 drained busy2", 128'(busy2_2), 128'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
